// File: rtl/instruction_decoder.sv
// instruction_decoder
//   Registers a 16-bit instruction word and splits it into fixed fields.
//   No opcode interpretation: every field is extracted on every enabled edge,
//   even where fields overlap (rAadrs/rBadrs/imm share instruct[7:0]).
//
// Ports
//   clock    in   1   rising-edge clock
//   reset    in   1   synchronous active-high reset (wins over enable)
//   enable   in   1   capture and decode instruct on this edge
//   instruct in  16   instruction word
//   opcode   out  4   instruct[15:12]
//   rDadrs   out  3   instruct[11:9]
//   flag     out  1   instruct[8]
//   rAadrs   out  3   instruct[7:5]
//   rBadrs   out  3   instruct[4:2]
//   imm      out  8   instruct[7:0]
module instruction_decoder (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] instruct,
  output logic [3:0]  opcode,
  output logic [2:0]  rDadrs,
  output logic [2:0]  rAadrs,
  output logic [2:0]  rBadrs,
  output logic [7:0]  imm,
  output logic        flag
);

  // All fields live in one register bank that is loaded under a single
  // condition, so the outputs always describe the same instruction.
  typedef struct packed {
    logic [3:0] opcode;
    logic [2:0] rd;
    logic       flag;
    logic [2:0] ra;
    logic [2:0] rb;
    logic [7:0] imm;
  } fields_t;

  fields_t fields_reg;
  fields_t fields_next;

  always_comb begin
    fields_next        = fields_reg;
    fields_next.opcode = instruct[15:12];
    fields_next.rd     = instruct[11:9];
    fields_next.flag   = instruct[8];
    fields_next.ra     = instruct[7:5];
    fields_next.rb     = instruct[4:2];
    fields_next.imm    = instruct[7:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fields_reg <= '0;
    end else if (enable) begin
      fields_reg <= fields_next;
    end
  end

  assign opcode = fields_reg.opcode;
  assign rDadrs = fields_reg.rd;
  assign flag   = fields_reg.flag;
  assign rAadrs = fields_reg.ra;
  assign rBadrs = fields_reg.rb;
  assign imm    = fields_reg.imm;

endmodule

// File: tb/tb_instruction_decoder.sv
// tb_instruction_decoder
//   Directed test of instruction_decoder. Each scenario task drives inputs
//   and compares the whole decoded field set against hand-computed values.
//   Observed word layout: {opcode, rDadrs, flag, rAadrs, rBadrs, imm} (22 bits).
module tb_instruction_decoder;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] instruct;
  logic [3:0]  opcode;
  logic [2:0]  rDadrs;
  logic [2:0]  rAadrs;
  logic [2:0]  rBadrs;
  logic [7:0]  imm;
  logic        flag;

  int checks = 0;
  int passed = 0;

  logic [21:0] got;
  assign got = {opcode, rDadrs, flag, rAadrs, rBadrs, imm};

  instruction_decoder dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .instruct (instruct),
    .opcode   (opcode),
    .rDadrs   (rDadrs),
    .rAadrs   (rAadrs),
    .rBadrs   (rBadrs),
    .imm      (imm),
    .flag     (flag)
  );

  always #5 clock = ~clock;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; instruct = 16'hFFFF;
    tick();
    tick();
    checks++;
    if (got !== 22'h0)
      $display("FAIL reset_2_edges got=%h exp=%h", got, 22'h0);
    else begin passed++; $display("check reset_2_edges got=%h", got); end

    // Released reset but no enable: still zero.
    reset = 1'b0; enable = 1'b0; instruct = 16'h6FAF;
    tick();
    checks++;
    if (got !== 22'h0)
      $display("FAIL zero_until_enable got=%h exp=%h", got, 22'h0);
    else begin passed++; $display("check zero_until_enable got=%h", got); end
  endtask

  task automatic test_back_to_back();
    logic [21:0] exp;
    enable = 1'b1; instruct = 16'h6FAF;
    tick();
    exp = {4'h6, 3'd7, 1'b1, 3'd5, 3'd3, 8'hAF};
    checks++;
    if (got !== exp)
      $display("FAIL decode_6FAF got=%h exp=%h", got, exp);
    else begin passed++; $display("check decode_6FAF got=%h", got); end

    instruct = 16'h7A9B;
    tick();
    exp = {4'h7, 3'd5, 1'b0, 3'd4, 3'd6, 8'h9B};
    checks++;
    if (got !== exp)
      $display("FAIL decode_7A9B got=%h exp=%h", got, exp);
    else begin passed++; $display("check decode_7A9B got=%h", got); end
  endtask

  task automatic test_hold();
    logic [21:0] exp;
    exp = {4'h7, 3'd5, 1'b0, 3'd4, 3'd6, 8'h9B};
    enable = 1'b0; instruct = 16'hABCD;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (got !== exp)
        $display("FAIL hold_edge%0d got=%h exp=%h", i, got, exp);
      else begin passed++; $display("check hold_edge%0d got=%h", i, got); end
    end

    enable = 1'b1;
    tick();
    exp = {4'hA, 3'd5, 1'b1, 3'd6, 3'd3, 8'hCD};
    checks++;
    if (got !== exp)
      $display("FAIL decode_ABCD got=%h exp=%h", got, exp);
    else begin passed++; $display("check decode_ABCD got=%h", got); end
  endtask

  task automatic test_reset_priority();
    reset = 1'b1; enable = 1'b1; instruct = 16'h1234;
    tick();
    checks++;
    if (got !== 22'h0)
      $display("FAIL reset_over_enable got=%h exp=%h", got, 22'h0);
    else begin passed++; $display("check reset_over_enable got=%h", got); end

    reset = 1'b0; enable = 1'b0; instruct = 16'hFFFF;
    tick();
    checks++;
    if (got !== 22'h0)
      $display("FAIL zero_after_reset got=%h exp=%h", got, 22'h0);
    else begin passed++; $display("check zero_after_reset got=%h", got); end
  endtask

  task automatic test_between_edges();
    logic [21:0] exp;
    enable = 1'b1; instruct = 16'h1234;
    tick();
    exp = {4'h1, 3'd1, 1'b0, 3'd1, 3'd5, 8'h34};
    checks++;
    if (got !== exp)
      $display("FAIL decode_1234 got=%h exp=%h", got, exp);
    else begin passed++; $display("check decode_1234 got=%h", got); end

    // Wiggle instruct between edges; nothing must move.
    instruct = 16'hFFFF;
    #2;
    instruct = 16'h0000;
    #2;
    checks++;
    if (got !== exp)
      $display("FAIL no_comb_path got=%h exp=%h", got, exp);
    else begin passed++; $display("check no_comb_path got=%h", got); end
  endtask

  task automatic test_low_bits();
    logic [21:0] exp;
    // Differs from 0x6FAF only in bits [1:0]: only imm may change.
    enable = 1'b1; instruct = 16'h6FAC;
    tick();
    exp = {4'h6, 3'd7, 1'b1, 3'd5, 3'd3, 8'hAC};
    checks++;
    if (got !== exp)
      $display("FAIL decode_6FAC got=%h exp=%h", got, exp);
    else begin passed++; $display("check decode_6FAC got=%h", got); end

    instruct = 16'h0103;
    tick();
    exp = {4'h0, 3'd0, 1'b1, 3'd0, 3'd0, 8'h03};
    checks++;
    if (got !== exp)
      $display("FAIL decode_0103 got=%h exp=%h", got, exp);
    else begin passed++; $display("check decode_0103 got=%h", got); end

    instruct = 16'h8E1C;
    tick();
    exp = {4'h8, 3'd7, 1'b0, 3'd0, 3'd7, 8'h1C};
    checks++;
    if (got !== exp)
      $display("FAIL decode_8E1C got=%h exp=%h", got, exp);
    else begin passed++; $display("check decode_8E1C got=%h", got); end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; instruct = 16'h0000;
    test_reset();
    test_back_to_back();
    test_hold();
    test_reset_priority();
    test_between_edges();
    test_low_bits();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
